// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the Program_Counter next value, issues single
// outstanding instruction-memory reads at PC, and buffers returned words with
// their PC in a small FIFO toward decode. Redirects flush the buffer and
// discard any in-flight read; misaligned redirect targets raise a sticky fault.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_Next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg;
    logic [31:0]     req_pc_reg;
    logic            fault_reg;

    logic [31:0]     buf_pc   [FIFO_DEPTH];
    logic [31:0]     buf_data [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   count_reg;
    logic [31:0]     instr_reg;
    logic [31:0]     instr_pc_reg;

    logic            req_fire;
    logic            push;
    logic            pop;

    // Requests only from FETCH with buffer room; the async reset also masks
    // the request so nothing is issued while the core is held in reset.
    assign imem_req_valid = rst && (state_reg == FETCH) && !fault_reg &&
                            (count_reg < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign imem_addr      = imem_req_valid ? PC : 32'h0;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid    = (count_reg != '0);
    assign push           = (state_reg == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign rd_ptr_inc     = rd_ptr_reg + 1'b1;

    assign instr          = instr_reg;
    assign instr_pc       = instr_pc_reg;
    assign fetch_fault    = fault_reg;

    // Next-PC selection: reset value, redirect target, advance on accepted request, else hold.
    always_comb begin
        PC_Next = PC;
        if (!rst) begin
            PC_Next = RESET_PC;
        end else if (redirect_valid) begin
            PC_Next = redirect_pc;
        end else if (req_fire) begin
            PC_Next = PC + 32'd4;
        end
    end

    // Fetch FSM: tracks the single outstanding read and the sticky alignment fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= FETCH;
            req_pc_reg <= 32'h0;
            fault_reg  <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fault_reg <= (redirect_pc[1:0] != 2'b00);
            end
            case (state_reg)
                FETCH: begin
                    if (req_fire) begin
                        state_reg  <= WAIT;
                        req_pc_reg <= PC;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_reg <= FETCH;
                    end else if (redirect_valid) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A response completing the stale read (even alongside a
                    // further redirect) leaves nothing outstanding.
                    if (imem_rsp_valid) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    // Buffer storage write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_reg]   <= req_pc_reg;
            buf_data[wr_ptr_reg] <= imem_rsp_data;
        end
    end

    // Buffer pointers, occupancy and registered head (held when the buffer empties).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            instr_reg    <= 32'h0;
            instr_pc_reg <= 32'h0;
        end else if (redirect_valid) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (push && ((count_reg == '0) || (pop && (count_reg == CW'(1))))) begin
                instr_reg    <= imem_rsp_data;
                instr_pc_reg <= req_pc_reg;
            end else if (pop && (count_reg > CW'(1))) begin
                instr_reg    <= buf_data[rd_ptr_inc];
                instr_pc_reg <= buf_pc[rd_ptr_inc];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a behavioural instruction memory with
// configurable latency, a PC register, and a scoreboard of expected
// {pc, data} entries checked as decode consumes them.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] PC_Next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (pc_q),
        .PC_Next        (PC_Next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program_Counter stand-in: registers PC_Next every edge
    always @(posedge clk) pc_q <= PC_Next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // memory model state
    int          lat = 0;
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr_l = 32'h0;

    // scoreboard / reference state
    logic [63:0] exp_q[$];
    logic [31:0] delivered[$];
    logic        pend_m = 1'b0;
    logic        discard_m = 1'b0;
    logic        fault_m = 1'b0;
    logic [31:0] fetch_pc_m = RESET_PC;
    logic [31:0] req_pc_m = 32'h0;
    logic        hs_last = 1'b0;
    logic        cond5_last = 1'b0;

    // memory response driver
    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr_l);
            end else begin
                mem_wait--;
            end
        end
        imem_req_ready = !mem_busy;
    end

    // monitor: compare against the reference, then advance it for the coming edge
    always @(negedge clk) begin
        logic        hs;
        logic        exp_req;
        logic [31:0] exp_next;
        logic [63:0] head;
        hs = rst && imem_req_valid && imem_req_ready;
        if (!rst) begin
            check_value("rst_pc_next", PC_Next, RESET_PC);
            check_value("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check_value("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
            check_value("rst_instr", instr, 32'h0);
            check_value("rst_instr_pc", instr_pc, 32'h0);
            check_value("rst_fault", {31'b0, fetch_fault}, 32'd0);
            exp_q.delete();
            pend_m     = 1'b0;
            discard_m  = 1'b0;
            fault_m    = 1'b0;
            fetch_pc_m = RESET_PC;
            hs_last    = 1'b0;
            cond5_last = 1'b0;
        end else begin
            exp_req = !pend_m && !fault_m && (exp_q.size() < DEPTH) && !redirect_valid;
            check_value("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (imem_req_valid) check_value("req_addr", imem_addr, fetch_pc_m);
            exp_next = redirect_valid ? redirect_pc : (hs ? pc_q + 32'd4 : pc_q);
            check_value("pc_next", PC_Next, exp_next);
            check_value("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
            if (instr_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                check_value("instr_pc", instr_pc, head[63:32]);
                check_value("instr", instr, head[31:0]);
            end
            check_value("fetch_fault", {31'b0, fetch_fault}, {31'b0, fault_m});

            if (redirect_valid) begin
                exp_q.delete();
                if (pend_m && !imem_rsp_valid) discard_m = 1'b1;
                else begin
                    pend_m    = 1'b0;
                    discard_m = 1'b0;
                end
                fault_m    = (redirect_pc[1:0] != 2'b00);
                fetch_pc_m = redirect_pc;
            end else begin
                if (instr_valid && instr_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    delivered.push_back(instr_pc);
                    $display("pop  pc=%h instr=%h", instr_pc, instr);
                end
                if (imem_rsp_valid && pend_m) begin
                    if (!discard_m) exp_q.push_back({req_pc_m, imem_rsp_data});
                    pend_m    = 1'b0;
                    discard_m = 1'b0;
                end
                if (hs) begin
                    pend_m     = 1'b1;
                    req_pc_m   = fetch_pc_m;
                    fetch_pc_m = fetch_pc_m + 32'd4;
                    $display("req  addr=%h", imem_addr);
                end
            end
            hs_last    = hs;
            cond5_last = hs && instr_valid;
        end
        if (imem_rsp_valid) mem_busy = 1'b0;
        if (hs) begin
            mem_busy   = 1'b1;
            mem_wait   = lat;
            mem_addr_l = imem_addr;
        end
    end

    task automatic wait_hs(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            found = hs_last;
        end
        check_value(tag, {31'b0, found}, 32'd1);
        #1;
    endtask

    task automatic check_first(input string tag, input logic [31:0] exp);
        check_value({tag, "_count"}, {31'b0, delivered.size() >= 1}, 32'd1);
        if (delivered.size() >= 1) check_value(tag, delivered[0], exp);
    endtask

    initial begin
        logic [31:0] saved;
        logic        found;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        delivered.delete();

        // 1: zero-wait sequential fetch
        repeat (20) @(posedge clk);
        check_value("t1_count", {31'b0, delivered.size() >= 4}, 32'd1);
        if (delivered.size() >= 4) begin
            check_value("t1_pc0", delivered[0], 32'h0);
            check_value("t1_pc1", delivered[1], 32'h4);
            check_value("t1_pc2", delivered[2], 32'h8);
            check_value("t1_pc3", delivered[3], 32'hC);
        end

        // 2: backpressure fills the buffer and freezes PC
        #1 instr_ready = 1'b0;
        repeat (12) @(posedge clk);
        saved = pc_q;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_value("t2_pc_frozen", pc_q, saved);
        check_value("t2_no_req", {31'b0, imem_req_valid}, 32'd0);
        check_value("t2_full", {31'b0, instr_valid}, 32'd1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        delivered.delete();
        repeat (12) @(posedge clk);
        check_value("t2_count", {31'b0, delivered.size() >= 3}, 32'd1);
        if (delivered.size() >= 3) begin
            check_value("t2_order1", delivered[1], delivered[0] + 32'd4);
            check_value("t2_order2", delivered[2], delivered[1] + 32'd4);
        end

        // 3: redirect while waiting on a slow response
        lat = 3;
        #1;
        wait_hs("t3_wait_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        delivered.delete();
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check_value("t3_flushed", {31'b0, instr_valid}, 32'd0);
        repeat (20) @(posedge clk);
        check_first("t3_target", 32'h100);

        // 4: misaligned redirect faults, aligned redirect recovers
        lat = 0;
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h202;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_value("t4_fault", {31'b0, fetch_fault}, 32'd1);
        check_value("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        delivered.delete();
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check_value("t4_fault_clr", {31'b0, fetch_fault}, 32'd0);
        repeat (10) @(posedge clk);
        check_first("t4_target", 32'h200);

        // 5: redirect coinciding with response and pop
        #1 instr_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            found = cond5_last;
        end
        check_value("t5_setup", {31'b0, found}, 32'd1);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        instr_ready    = 1'b1;
        delivered.delete();
        @(negedge clk);
        check_value("t5_rsp", {31'b0, imem_rsp_valid}, 32'd1);
        check_value("t5_head", {31'b0, instr_valid}, 32'd1);
        check_value("t5_pc_next", PC_Next, 32'h300);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check_value("t5_empty", {31'b0, instr_valid}, 32'd0);
        repeat (10) @(posedge clk);
        check_first("t5_target", 32'h300);

        // 6: reset while waiting; the late response must be ignored
        lat = 3;
        #1;
        wait_hs("t6_wait_req");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        delivered.delete();
        repeat (15) @(posedge clk);
        check_first("t6_reset_pc", RESET_PC);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
